// File: rtl/pe_array_sched.sv
// Batch scheduler for NUM_PE pe tiles: buffers one load burst at a time and replays it gap-free to a PE,
// captures every PE's output burst, then drains all results in PE order over a valid/ready port.
module pe_array_sched #(
  parameter int NUM_PE   = 4,
  parameter int DW       = 32,
  parameter int LOAD_NUM = 16,
  parameter int OUT_NUM  = 4,
  parameter int IDX_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  output logic [NUM_PE-1:0]    pe_din_v,
  output logic [DW-1:0]        pe_din,
  input  logic [NUM_PE-1:0]    pe_dout_v,
  input  logic [NUM_PE*DW-1:0] pe_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic [IDX_W-1:0]     m_pe_idx,
  output logic                 busy,
  output logic                 batch_done,
  output logic                 err
);

  localparam int TOT = NUM_PE * OUT_NUM;
  localparam int LW  = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
  localparam int OW  = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int DRW = (TOT > 1) ? $clog2(TOT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_pe_sel;
  logic [LW-1:0]     r_word_cnt;
  logic [OW-1:0]     r_out_cnt [NUM_PE];
  logic [NUM_PE-1:0] r_done;
  logic              r_err;
  logic [DRW-1:0]    r_drn_cnt;
  logic              r_m_valid;
  logic [DW-1:0]     r_m_data;
  logic [IDX_W-1:0]  r_m_pe_idx;
  logic              r_batch_done;
  logic [NUM_PE-1:0] r_pe_din_v;
  logic [DW-1:0]     r_pe_din;
  logic [DW-1:0]     r_fbuf [LOAD_NUM];
  logic [DW-1:0]     r_obuf [TOT];

  logic           w_s_fire;
  logic           w_cap_en;
  logic           w_last_word;
  logic           w_drn_last;
  logic [DRW-1:0] w_drn_nxt;
  logic           w_m_fire;

  assign w_s_fire    = s_valid && (r_state == S_FILL);
  assign w_cap_en    = (r_state == S_FILL) || (r_state == S_SEND) || (r_state == S_WAIT);
  assign w_last_word = (r_word_cnt == LW'(LOAD_NUM - 1));
  assign w_drn_last  = (r_drn_cnt == DRW'(TOT - 1));
  assign w_drn_nxt   = r_drn_cnt + DRW'(1);
  assign w_m_fire    = r_m_valid && m_ready;

  assign s_ready    = (r_state == S_FILL);
  assign busy       = (r_state != S_IDLE);
  assign pe_din_v   = r_pe_din_v;
  assign pe_din     = r_pe_din;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_pe_idx   = r_m_pe_idx;
  assign batch_done = r_batch_done;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pe_sel     <= '0;
      r_word_cnt   <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_drn_cnt    <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_pe_idx   <= '0;
      r_batch_done <= 1'b0;
      r_pe_din_v   <= '0;
      r_pe_din     <= '0;
      for (int k = 0; k < NUM_PE; k++) r_out_cnt[k] <= '0;
    end else begin
      r_batch_done <= 1'b0;
      r_pe_din_v   <= '0;
      r_pe_din     <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FILL;
            r_pe_sel   <= '0;
            r_word_cnt <= '0;
            r_done     <= '0;
            for (int k = 0; k < NUM_PE; k++) r_out_cnt[k] <= '0;
          end
        end
        S_FILL: begin
          if (s_valid) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + LW'(1);
            if (w_last_word) r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // Replay is one cycle behind the state, so the PE sees LOAD_NUM unbroken cycles.
          r_pe_din_v <= NUM_PE'(1) << r_pe_sel;
          r_pe_din   <= r_fbuf[r_word_cnt];
          r_word_cnt <= w_last_word ? '0 : r_word_cnt + LW'(1);
          if (w_last_word) begin
            if (r_pe_sel == IDX_W'(NUM_PE - 1)) begin
              r_state <= S_WAIT;
            end else begin
              r_pe_sel <= r_pe_sel + IDX_W'(1);
              r_state  <= S_FILL;
            end
          end
        end
        S_WAIT: begin
          if (&r_done) begin
            r_state    <= S_DRAIN;
            r_drn_cnt  <= '0;
            r_m_valid  <= 1'b1;
            r_m_data   <= r_obuf[0];
            r_m_pe_idx <= '0;
          end
        end
        S_DRAIN: begin
          if (w_m_fire) begin
            if (w_drn_last) begin
              r_state      <= S_IDLE;
              r_m_valid    <= 1'b0;
              r_m_data     <= '0;
              r_m_pe_idx   <= '0;
              r_batch_done <= 1'b1;
            end else begin
              r_drn_cnt  <= w_drn_nxt;
              r_m_data   <= r_obuf[w_drn_nxt];
              r_m_pe_idx <= IDX_W'(w_drn_nxt / DRW'(OUT_NUM));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Output words arriving outside the capture window or after a PE's burst completed are dropped.
      for (int k = 0; k < NUM_PE; k++) begin
        if (pe_dout_v[k]) begin
          if (!w_cap_en || r_done[k]) begin
            r_err <= 1'b1;
          end else if (r_out_cnt[k] == OW'(OUT_NUM - 1)) begin
            r_done[k] <= 1'b1;
          end else begin
            r_out_cnt[k] <= r_out_cnt[k] + OW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_fire) r_fbuf[r_word_cnt] <= s_data;
    for (int k = 0; k < NUM_PE; k++) begin
      if (w_cap_en && pe_dout_v[k] && !r_done[k])
        r_obuf[DRW'(k * OUT_NUM) + DRW'(r_out_cnt[k])] <= pe_dout[k*DW +: DW];
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized bench for pe_array_sched: behavioural PE models, input feeder and result consumer
// checked against per-batch expectations derived from the fed stream.
module tb_pe_array_sched;
  localparam int NUM_PE = 4, DW = 32, LOAD_NUM = 16, OUT_NUM = 4, IDX_W = 2;
  localparam int TOT = NUM_PE * OUT_NUM;

  logic                 clk, rst, start, s_valid, s_ready;
  logic [DW-1:0]        s_data;
  logic [NUM_PE-1:0]    pe_din_v, pe_dout_v;
  logic [DW-1:0]        pe_din;
  logic [NUM_PE*DW-1:0] pe_dout;
  logic                 m_valid, m_ready, busy, batch_done, err;
  logic [DW-1:0]        m_data;
  logic [IDX_W-1:0]     m_pe_idx;

  pe_array_sched #(.NUM_PE(NUM_PE), .DW(DW), .LOAD_NUM(LOAD_NUM), .OUT_NUM(OUT_NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pe_din_v(pe_din_v), .pe_din(pe_din), .pe_dout_v(pe_dout_v), .pe_dout(pe_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_pe_idx(m_pe_idx),
    .busy(busy), .batch_done(batch_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] base;
  bit          inj;
  int          rmode;

  // Behavioural PE models and load-port monitor
  int          ld_cnt [NUM_PE];
  logic [31:0] ld_sum [NUM_PE];
  int          ret_at [NUM_PE];
  int          ret_j  [NUM_PE];
  logic [31:0] out_val [NUM_PE][OUT_NUM];
  bit          inj_done;
  logic [NUM_PE-1:0] prev_v;
  int          run, cyc;

  task automatic clear_model();
    for (int k = 0; k < NUM_PE; k++) begin
      ld_cnt[k] = 0; ld_sum[k] = 0; ret_at[k] = -1; ret_j[k] = 0;
    end
    inj_done = 0;
  endtask

  initial begin
    logic [31:0] val;
    pe_dout_v = '0; pe_dout = '0; cyc = 0; prev_v = '0; run = 0;
    clear_model();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        clear_model(); prev_v = '0; run = 0; pe_dout_v = '0; pe_dout = '0;
      end else begin
        if (pe_din_v != '0) begin
          chk("din_onehot", 32'($onehot(pe_din_v)), 32'd1);
          for (int k = 0; k < NUM_PE; k++) begin
            if (pe_din_v[k]) begin
              chk("din_data", pe_din, base + 32'(k * LOAD_NUM + ld_cnt[k]));
              ld_cnt[k]++;
              ld_sum[k] = ld_sum[k] + pe_din;
              if (ld_cnt[k] == LOAD_NUM) begin
                case (k)
                  0: ;
                  1: ret_at[1] = cyc + 3;
                  2: begin ret_at[2] = cyc + 1; ret_at[0] = cyc + 1; end
                  default: ret_at[k] = cyc + 2;
                endcase
              end
            end
          end
        end else begin
          chk("din_zero", pe_din, 32'd0);
        end
        if (pe_din_v != prev_v) begin
          if (prev_v != '0) chk("burst_len", run, LOAD_NUM);
          run = 1;
        end else begin
          run++;
        end
        prev_v = pe_din_v;
        if (batch_done) begin
          for (int k = 0; k < NUM_PE; k++) begin
            chk("pe_loaded", ld_cnt[k], LOAD_NUM);
            chk("pe_returned", ret_j[k], OUT_NUM);
          end
        end
        if (!busy) clear_model();
        pe_dout_v = '0; pe_dout = '0;
        for (int k = 0; k < NUM_PE; k++) begin
          if (ret_at[k] >= 0 && cyc >= ret_at[k] && ret_j[k] < OUT_NUM) begin
            val = ld_sum[k] + (32'(ret_j[k]) << 20) + (32'(k) << 28);
            out_val[k][ret_j[k]] = val;
            pe_dout_v[k] = 1'b1;
            pe_dout[k*DW +: DW] = val;
            ret_j[k]++;
          end else if (k == 1 && inj && !inj_done && ret_j[1] == OUT_NUM) begin
            pe_dout_v[1] = 1'b1;
            pe_dout[DW +: DW] = 32'hDEAD_BEEF;
            inj_done = 1;
          end
        end
      end
    end
  end

  // Result consumer
  int          n_acc, bd_cnt;
  bit          stalled;
  logic [31:0] held;

  initial begin
    m_ready = 1'b0; n_acc = 0; bd_cnt = 0; stalled = 0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ready = 1'b0; stalled = 0;
      end else begin
        if (batch_done) bd_cnt++;
        if (stalled) begin
          chk("m_hold_v", m_valid, 32'd1);
          chk("m_hold_d", m_data, held);
        end
        if (m_valid) begin
          m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          if (m_ready) begin
            if (n_acc < TOT) begin
              chk("m_data", m_data, out_val[n_acc / OUT_NUM][n_acc % OUT_NUM]);
              chk("m_pe_idx", 32'(m_pe_idx), 32'(n_acc / OUT_NUM));
            end else begin
              chk("m_extra", n_acc, TOT - 1);
            end
            n_acc++;
            stalled = 0;
          end else begin
            stalled = 1;
            held = m_data;
          end
        end else begin
          m_ready = 1'($urandom_range(0, 1));
          stalled = 0;
        end
      end
    end
  end

  task automatic feed(input int n, input bit gap);
    int sent, guard;
    sent = 0; guard = 0;
    while (sent < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      s_valid = gap ? ($urandom_range(0, 2) == 0) : 1'b1;
      s_data  = base + 32'(sent);
      if (s_valid && s_ready) sent++;
    end
    chk("feed_done", sent, n);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_batch(input logic [31:0] b, input bit gap, input int rm);
    int guard;
    base = b; rmode = rm; n_acc = 0; bd_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start", busy, 32'd1);
    feed(LOAD_NUM * NUM_PE, gap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (bd_cnt == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("batch_done_seen", 32'(bd_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
    chk("batch_done_once", bd_cnt, 32'd1);
    chk("words_drained", n_acc, TOT);
    chk("busy_end", busy, 32'd0);
    chk("m_valid_end", m_valid, 32'd0);
    chk("err_clean", err, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = '0;
    base = '0; inj = 0; rmode = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_pe_din_v", pe_din_v, 0);
    chk("rst_pe_din", pe_din, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_pe_idx", m_pe_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_err", err, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", busy, 0);

    run_batch(32'h1, 1'b0, 0);
    run_batch($urandom, 1'b1, 0);
    run_batch($urandom, 1'b1, 1);

    // Late word from a finished PE, then reset in the middle of PE2's replay
    base = $urandom; inj = 1; rmode = 0; n_acc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(LOAD_NUM * 3, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_sticky", err, 32'd1);
    chk("mid_send_pe2", pe_din_v, 32'h4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; inj = 0;
    @(negedge clk);
    chk("post_rst_err", err, 0);
    chk("post_rst_din_v", pe_din_v, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_s_ready", s_ready, 0);

    run_batch($urandom, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
